// File: rtl/gf180mcu_fd_sc_mcu7t5v0__demux4_reg.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__demux4_reg
//
// Registered 1-to-4 demultiplexer with valid/ready flow control. One input
// stream is steered into one of four single-entry channel registers, chosen
// either by the static select pins {S1,S0} or by an internal round-robin
// pointer (AUTO=1). Each channel drains independently toward its consumer.
//
// Ports:
//   CLK            clock, rising edge
//   RN             asynchronous active-low reset
//   I  [WIDTH]     input data
//   IV / IR        input valid / input ready
//   S0, S1         static channel select {S1,S0}, used when AUTO=0
//   AUTO           1: steer via round-robin pointer PTR
//   Z0..Z3 [WIDTH] channel data registers (meaningful only while ZVk=1)
//   ZV0..ZV3       channel valid
//   ZR0..ZR3       channel ready from consumer
//   PTR [2]        round-robin pointer
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__demux4_reg #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] I,
    input  logic             IV,
    output logic             IR,
    input  logic             S0,
    input  logic             S1,
    input  logic             AUTO,
    output logic [WIDTH-1:0] Z0,
    output logic [WIDTH-1:0] Z1,
    output logic [WIDTH-1:0] Z2,
    output logic [WIDTH-1:0] Z3,
    output logic             ZV0,
    output logic             ZV1,
    output logic             ZV2,
    output logic             ZV3,
    input  logic             ZR0,
    input  logic             ZR1,
    input  logic             ZR2,
    input  logic             ZR3,
    output logic [1:0]       PTR
);

    logic [WIDTH-1:0] z_q [4];
    logic [WIDTH-1:0] z_d [4];
    logic [3:0]       zv_q, zv_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [3:0]       zr;
    logic [1:0]       sel;
    logic             acc;

    assign zr  = {ZR3, ZR2, ZR1, ZR0};
    assign sel = AUTO ? ptr_q : {S1, S0};

    // Ready looks only at the selected channel's state and its consumer, so a
    // full channel being drained this cycle can still accept (full throughput).
    // There is deliberately no path from IV into IR.
    assign IR  = ~zv_q[sel] | zr[sel];
    assign acc = IV & IR;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block leaves it unassigned (which would infer a latch).
        z_d   = z_q;
        zv_d  = zv_q;
        ptr_d = ptr_q;

        for (int k = 0; k < 4; k++) begin
            if (acc && (sel == 2'(k))) begin
                // A load beats a simultaneous drain on the same channel.
                z_d[k]  = I;
                zv_d[k] = 1'b1;
            end else if (zv_q[k] && zr[k]) begin
                // Drain: data register keeps its last value, only valid drops.
                zv_d[k] = 1'b0;
            end
        end

        // Round-robin stalls on a full channel (no acc) rather than skipping it.
        if (acc && AUTO) begin
            ptr_d = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            // NOTE: the data registers are reset too, since their cleared value
            // is externally observable; a storage block with no such contract
            // would normally leave data unreset.
            for (int k = 0; k < 4; k++) begin
                z_q[k] <= '0;
            end
            zv_q  <= '0;
            ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            for (int k = 0; k < 4; k++) begin
                z_q[k] <= z_d[k];
            end
            zv_q  <= zv_d;
            ptr_q <= ptr_d;
        end
    end

    assign Z0  = z_q[0];
    assign Z1  = z_q[1];
    assign Z2  = z_q[2];
    assign Z3  = z_q[3];
    assign ZV0 = zv_q[0];
    assign ZV1 = zv_q[1];
    assign ZV2 = zv_q[2];
    assign ZV3 = zv_q[3];
    assign PTR = ptr_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__demux4_reg.md
# gf180mcu_fd_sc_mcu7t5v0__demux4_reg

Registered 1-to-4 demultiplexer with valid/ready flow control: it is the distributing counterpart of the 4:1 `mux4` cell. One input stream is steered to one of four output channels, chosen either by static select pins `S1:S0` or by an internal round-robin pointer. Each output channel has a one-entry holding register. The block sits at the fan-out point of an MCU data path, where one producer feeds four independent consumers.

## Interface
Parameters:
- `WIDTH`, default 1: data width of the input and of each output channel.

Ports:
- `CLK` input 1: clock; all state updates on the rising edge.
- `RN` input 1: asynchronous, active-low reset.
- `I` input WIDTH: input data.
- `IV` input 1: input valid.
- `IR` output 1: input ready.
- `S0`, `S1` input 1 each: static channel select, `{S1,S0}`; used when `AUTO=0`.
- `AUTO` input 1: 1 selects round-robin steering via `PTR`.
- `Z0`..`Z3` output WIDTH each: channel data registers.
- `ZV0`..`ZV3` output 1 each: channel valid.
- `ZR0`..`ZR3` input 1 each: channel ready from the consumer.
- `PTR` output 2: round-robin pointer.

## Operation
- Channel select: `sel = AUTO ? PTR : {S1,S0}`.
- `IR = ~ZV[sel] | ZR[sel]`. This is combinational from registers and `ZR`, with no path from `IV`.
- Transfer: `acc = IV & IR`.
- Per-channel update, for each k:
  - If `acc` and `sel==k`: `Zk <= I`, `ZVk <= 1`.
  - Else if `ZVk & ZRk`: `ZVk <= 0`, and `Zk` holds its last value.
  - Otherwise the channel holds.
- Non-selected channels drain independently in the same cycle. Up to four drains plus one load can occur per cycle.
- `PTR`:
  - `PTR <= PTR+1` (mod 4, so 3 wraps to 0) on `acc` when `AUTO=1`.
  - `PTR` holds when `AUTO=0`.
  - The `AUTO` value sampled in the same cycle as `acc` decides the increment.
- `ZRk` is ignored while `ZVk=0`.
- `Zk` is valid only while `ZVk=1`. The bench must not check `Zk` otherwise.
- The source may change `I`, `IV`, `S0`/`S1` or `AUTO` freely while `acc=0`. The block imposes no input-stability rule.

## Timing
- Reset (`RN=0`, asynchronous, independent of `CLK`):
  - `Z0..Z3 = 0`, `ZV0..ZV3 = 0`, `PTR = 0`.
  - `IR = 1` as a consequence.
- Release of `RN` is synchronous to the next rising `CLK`. The first transfer is possible on the first edge after release.
- Latency: one cycle. Data accepted at edge n appears on `Zk` with `ZVk=1` after edge n.
- Throughput: one transfer per cycle. This holds into the same channel when its consumer holds `ZRk=1`, because `IR` passes through `ZR[sel]`.
- Full channel: when `ZV[sel]=1` and `ZR[sel]=0`, `IR=0`. There is no accept, no `PTR` advance, and the other channels are unaffected. Round-robin stalls on the full channel; it does not skip it.
- Simultaneous load and drain on the same channel: the load wins. `ZVk` stays 1 and `Zk` takes the new `I`.
- Reset mid-operation: all pending channel data is discarded and `PTR` returns to 0 immediately. No partial transfer survives.
- Switching `AUTO` 1→0→1: `PTR` resumes from its held value, not from 0.

## Test plan
- Reset, `WIDTH=8`: assert `RN=0` mid-cycle → `ZV0..3=0`, `Z0..3=0x00`, `PTR=0`, `IR=1` immediately, without waiting for a clock edge.
- Static steering, `AUTO=0`, all `ZR=1`:
  - Send `0xA0`, `0xA1`, `0xA2`, `0xA3` with `{S1,S0}=0,1,2,3` on consecutive cycles.
  - Each `Zk=0xAk` with `ZVk=1` for exactly one cycle, one cycle after its accept.
  - `PTR` stays 0.
- Round-robin wrap, `AUTO=1`, all `ZR=1`:
  - Six back-to-back transfers `0x10..0x15`.
  - They land on channels 0,1,2,3,0,1.
  - `PTR` sequence is 1,2,3,0,1,2.
- Backpressure, `AUTO=0`, `sel=2`, `ZR2=0`:
  - First `0x55` is accepted, then `IR=0`.
  - Second `0x66` is held off while `Z2` stays `0x55`.
  - Raise `ZR2`: `0x66` is accepted in that same cycle and `Z2=0x66` on the next cycle.
- Concurrent activity:
  - Channel 1 full with `ZR1=1` draining, while a load targets channel 3 in the same cycle → `ZV1` falls and `ZV3` rises at that edge.
  - Load plus drain on channel 0 in the same cycle → `ZV0` stays 1 with the new data.
- Reset mid-stream, `AUTO=1`, `PTR=2`, channels 0 and 1 valid: pulse `RN` → all `ZV=0`, `PTR=0`. The next transfer lands on channel 0.
